// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions, condition codes and the
// controller state encoding. Also used by the branch unit.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b1000;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // CMP always updates flags; other ops only with S set, and NOP never does.
  function automatic logic commits_flags(input logic [3:0] opcode, input logic s_bit);
    return (opcode == OP_CMP) || (s_bit && (opcode != OP_NOP));
  endfunction

endpackage

// File: rtl/alu_controller_cond_eval.sv
// Combinational condition-code evaluator: decides whether an instruction with
// condition field cond executes given flags {N,Z,C,V}.
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_controller.sv
// Single-outstanding instruction sequencer in front of the ALU. Owns the
// architectural {N,Z,C,V} register and evaluates conditions against it.
module alu_controller
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_opcode,
  input  logic        req_s_bit,
  input  logic [3:0]  req_cond,
  input  logic [31:0] req_in1,
  input  logic [31:0] req_in2,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [3:0]  alu_opcode,
  output logic        alu_s_bit,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_executed,
  output logic [3:0]  flags_q
);

  localparam logic [3:0] LAT_INIT = 4'(ALU_LATENCY);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  flags_d;
  logic [31:0] alu_in1_q, alu_in1_d;
  logic [31:0] alu_in2_q, alu_in2_d;
  logic [3:0]  alu_opcode_q, alu_opcode_d;
  logic        alu_s_bit_q, alu_s_bit_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_executed_q, rsp_executed_d;
  logic        cond_pass;

  cond_eval u_cond_eval (
    .cond  (req_cond),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    flags_d        = flags_q;
    alu_in1_d      = alu_in1_q;
    alu_in2_d      = alu_in2_q;
    alu_opcode_d   = alu_opcode_q;
    alu_s_bit_d    = alu_s_bit_q;
    rsp_result_d   = rsp_result_q;
    rsp_executed_d = rsp_executed_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          alu_in1_d    = req_in1;
          alu_in2_d    = req_in2;
          alu_opcode_d = req_opcode;
          alu_s_bit_d  = req_s_bit;
          if (cond_pass) begin
            state_d = ST_EXEC;
            cnt_d   = LAT_INIT;
          end else begin
            state_d        = ST_RESP;
            rsp_result_d   = 32'd0;
            rsp_executed_d = 1'b0;
          end
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - 4'd1;
        // <= rather than == so an out-of-range latency of 0 cannot lock up the FSM.
        if (cnt_q <= 4'd1) begin
          state_d        = ST_RESP;
          cnt_d          = 4'd0;
          rsp_result_d   = alu_result;
          rsp_executed_d = 1'b1;
          if (commits_flags(alu_opcode_q, alu_s_bit_q)) begin
            flags_d = alu_flags;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      flags_q        <= 4'b0000;
      alu_in1_q      <= 32'd0;
      alu_in2_q      <= 32'd0;
      alu_opcode_q   <= OP_NOP;
      alu_s_bit_q    <= 1'b0;
      rsp_result_q   <= 32'd0;
      rsp_executed_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      flags_q        <= flags_d;
      alu_in1_q      <= alu_in1_d;
      alu_in2_q      <= alu_in2_d;
      alu_opcode_q   <= alu_opcode_d;
      alu_s_bit_q    <= alu_s_bit_d;
      rsp_result_q   <= rsp_result_d;
      rsp_executed_q <= rsp_executed_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_result   = rsp_result_q;
  assign rsp_executed = rsp_executed_q;
  assign alu_in1      = alu_in1_q;
  assign alu_in2      = alu_in2_q;
  assign alu_opcode   = alu_opcode_q;
  assign alu_s_bit    = alu_s_bit_q;

endmodule

// File: tb/tb_alu_controller.sv
// Bench for alu_controller: one instance at latency 1 for functional scenarios,
// one at latency 3 for timing, hold and mid-operation reset.
module tb_alu_controller;

  typedef struct {
    logic [31:0] result;
    logic        exec;
    logic [3:0]  flags;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid3;
  logic [3:0]  req_opcode, req_cond;
  logic        req_s_bit;
  logic [31:0] req_in1, req_in2;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        rsp_ready, rsp_ready3;

  logic        req_ready, rsp_valid, rsp_executed, alu_s_bit;
  logic [31:0] alu_in1, alu_in2, rsp_result;
  logic [3:0]  alu_opcode, flags_q;

  logic        req_ready3, rsp_valid3, rsp_executed3, alu_s_bit3;
  logic [31:0] alu_in1_3, alu_in2_3, rsp_result3;
  logic [3:0]  alu_opcode3, flags3;

  logic        snap_ready;
  logic [31:0] snap_in1, snap_in2;
  logic [3:0]  snap_op;

  always #5 clk = ~clk;

  alu_controller #(.ALU_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_s_bit(req_s_bit), .req_cond(req_cond),
    .req_in1(req_in1), .req_in2(req_in2), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_opcode(alu_opcode), .alu_s_bit(alu_s_bit), .alu_result(alu_result),
    .alu_flags(alu_flags), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_executed(rsp_executed), .flags_q(flags_q)
  );

  alu_controller #(.ALU_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_opcode(req_opcode), .req_s_bit(req_s_bit), .req_cond(req_cond),
    .req_in1(req_in1), .req_in2(req_in2), .alu_in1(alu_in1_3), .alu_in2(alu_in2_3),
    .alu_opcode(alu_opcode3), .alu_s_bit(alu_s_bit3), .alu_result(alu_result),
    .alu_flags(alu_flags), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_result(rsp_result3), .rsp_executed(rsp_executed3), .flags_q(flags3)
  );

  // Reference condition table: even codes test a base predicate, odd codes its inverse.
  function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return cond[0] ? ~base : base;
  endfunction

  // Drive one request into the latency-1 instance; returns at the negedge after acceptance.
  task automatic send(input logic [3:0] op, input logic s, input logic [3:0] cond,
                      input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    req_opcode = op; req_s_bit = s; req_cond = cond; req_in1 = a; req_in2 = b;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 20) begin
      n_errors++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    snap_ready = req_ready; snap_in1 = alu_in1; snap_in2 = alu_in2; snap_op = alu_opcode;
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    while (!rsp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_executed, flags_q, rsp_result} !== {1'b1, 1'b0, 1'b0, 4'h0, 32'h0}) begin
      n_errors++;
      $display("FAIL reset_rsp: rdy=%b vld=%b exe=%b flags=%h res=%h, required 1 0 0 0 0",
               req_ready, rsp_valid, rsp_executed, flags_q, rsp_result);
    end
    n_checks++;
    if ({alu_in1, alu_in2, alu_opcode, alu_s_bit} !== {32'h0, 32'h0, 4'hF, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_alu: in1=%h in2=%h op=%h s=%b, required 0 0 f 0",
               alu_in1, alu_in2, alu_opcode, alu_s_bit);
    end
    n_checks++;
    if ({req_ready3, rsp_valid3, flags3, alu_opcode3} !== {1'b1, 1'b0, 4'h0, 4'hF}) begin
      n_errors++;
      $display("FAIL reset_lat3: rdy=%b vld=%b flags=%h op=%h, required 1 0 0 f",
               req_ready3, rsp_valid3, flags3, alu_opcode3);
    end
    $display("txn reset done");
  endtask

  task automatic test_add_wrap();
    exp_t e;
    int k;
    alu_result = 32'h0; alu_flags = 4'b0110;
    sb.push_back('{result: 32'h0, exec: 1'b1, flags: 4'b0110, lat: 1});
    send(4'b0000, 1'b1, 4'b1110, 32'hFFFF_FFFF, 32'h1);
    n_checks++;
    if ({snap_ready, snap_in1, snap_in2, snap_op} !== {1'b0, 32'hFFFF_FFFF, 32'h1, 4'b0000}) begin
      n_errors++;
      $display("FAIL add_alu_drive: rdy=%b in1=%h in2=%h op=%h, required 0 ffffffff 1 0",
               snap_ready, snap_in1, snap_in2, snap_op);
    end
    wait_rsp(k);
    e = sb.pop_front();
    n_checks++;
    if (k !== e.lat) begin n_errors++; $display("FAIL add_latency: got %0d, required %0d", k, e.lat); end
    n_checks++;
    if ({rsp_result, rsp_executed, flags_q} !== {e.result, e.exec, e.flags}) begin
      n_errors++;
      $display("FAIL add_rsp: res=%h exe=%b flags=%h, required %h %b %h",
               rsp_result, rsp_executed, flags_q, e.result, e.exec, e.flags);
    end
    $display("txn ADD res=%h exe=%b flags=%h", rsp_result, rsp_executed, flags_q);
    release_rsp();
  endtask

  task automatic test_skip();
    exp_t e;
    int k;
    alu_result = 32'h1234; alu_flags = 4'b0100;
    sb.push_back('{result: 32'h1234, exec: 1'b1, flags: 4'b0100, lat: 1});
    send(4'b0000, 1'b1, 4'b1110, 32'h5, 32'h6);
    wait_rsp(k);
    e = sb.pop_front();
    n_checks++;
    if ({k, rsp_result, rsp_executed, flags_q} !== {e.lat, e.result, e.exec, e.flags}) begin
      n_errors++;
      $display("FAIL skip_setup: lat=%0d res=%h exe=%b flags=%h, required %0d %h %b %h",
               k, rsp_result, rsp_executed, flags_q, e.lat, e.result, e.exec, e.flags);
    end
    $display("txn ADD(setZ) res=%h flags=%h", rsp_result, flags_q);
    release_rsp();
    alu_result = 32'hDEAD_BEEF; alu_flags = 4'b1111;
    sb.push_back('{result: 32'h0, exec: 1'b0, flags: 4'b0100, lat: 0});
    send(4'b0001, 1'b1, 4'b0001, 32'h7, 32'h8);
    wait_rsp(k);
    e = sb.pop_front();
    n_checks++;
    if (k !== e.lat) begin n_errors++; $display("FAIL skip_latency: got %0d, required %0d", k, e.lat); end
    n_checks++;
    if ({rsp_result, rsp_executed, flags_q} !== {e.result, e.exec, e.flags}) begin
      n_errors++;
      $display("FAIL skip_rsp: res=%h exe=%b flags=%h, required %h %b %h",
               rsp_result, rsp_executed, flags_q, e.result, e.exec, e.flags);
    end
    $display("txn SUB(NE,skipped) res=%h exe=%b flags=%h", rsp_result, rsp_executed, flags_q);
    release_rsp();
  endtask

  task automatic test_cmp_nop();
    exp_t e;
    int k;
    alu_result = 32'h77; alu_flags = 4'b1000;
    sb.push_back('{result: 32'h77, exec: 1'b1, flags: 4'b1000, lat: 1});
    send(4'b1000, 1'b0, 4'b1110, 32'h1, 32'h2);
    wait_rsp(k);
    e = sb.pop_front();
    n_checks++;
    if ({k, rsp_result, rsp_executed, flags_q} !== {e.lat, e.result, e.exec, e.flags}) begin
      n_errors++;
      $display("FAIL cmp_rsp: lat=%0d res=%h exe=%b flags=%h, required %0d %h %b %h",
               k, rsp_result, rsp_executed, flags_q, e.lat, e.result, e.exec, e.flags);
    end
    $display("txn CMP res=%h flags=%h", rsp_result, flags_q);
    release_rsp();
    alu_result = 32'h55; alu_flags = 4'b0101;
    sb.push_back('{result: 32'h55, exec: 1'b1, flags: 4'b1000, lat: 1});
    send(4'b1111, 1'b1, 4'b1110, 32'h3, 32'h4);
    wait_rsp(k);
    e = sb.pop_front();
    n_checks++;
    if ({k, rsp_result, rsp_executed, flags_q} !== {e.lat, e.result, e.exec, e.flags}) begin
      n_errors++;
      $display("FAIL nop_rsp: lat=%0d res=%h exe=%b flags=%h, required %0d %h %b %h",
               k, rsp_result, rsp_executed, flags_q, e.lat, e.result, e.exec, e.flags);
    end
    $display("txn NOP(s=1) res=%h flags=%h", rsp_result, flags_q);
    release_rsp();
  endtask

  task automatic test_latency3_hold();
    exp_t e;
    int k, n;
    logic [31:0] base;
    base = 32'hA000_0000; alu_flags = 4'b1111; n = 0;
    sb.push_back('{result: base + 32'd2, exec: 1'b1, flags: 4'b0000, lat: 3});
    @(negedge clk);
    req_opcode = 4'b0000; req_s_bit = 1'b0; req_cond = 4'b1110;
    req_in1 = 32'h11; req_in2 = 32'h22; req_valid3 = 1'b1;
    while (!req_ready3 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid3 = 1'b0;
    alu_result = base;
    k = 0;
    // Ramp the ALU result every cycle so the captured value pins the capture edge.
    forever begin
      @(negedge clk);
      if (rsp_valid3 || k >= 20) break;
      @(posedge clk);
      k++;
      #1 alu_result = base + 32'(k);
    end
    e = sb.pop_front();
    n_checks++;
    if (k !== e.lat) begin n_errors++; $display("FAIL lat3_latency: got %0d, required %0d", k, e.lat); end
    n_checks++;
    if ({rsp_result3, rsp_executed3, flags3} !== {e.result, e.exec, e.flags}) begin
      n_errors++;
      $display("FAIL lat3_rsp: res=%h exe=%b flags=%h, required %h %b %h",
               rsp_result3, rsp_executed3, flags3, e.result, e.exec, e.flags);
    end
    $display("txn ADD(lat3) res=%h lat=%0d flags=%h", rsp_result3, k, flags3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 alu_result = $urandom;
      @(negedge clk);
      n_checks++;
      if ({rsp_valid3, rsp_result3, rsp_executed3, req_ready3} !== {1'b1, e.result, 1'b1, 1'b0}) begin
        n_errors++;
        $display("FAIL lat3_hold[%0d]: vld=%b res=%h exe=%b rdy=%b, required 1 %h 1 0",
                 i, rsp_valid3, rsp_result3, rsp_executed3, req_ready3, e.result);
      end
    end
    rsp_ready3 = 1'b1;
    @(posedge clk);
    #1 rsp_ready3 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid3, req_ready3} !== 2'b01) begin
      n_errors++;
      $display("FAIL lat3_release: vld=%b rdy=%b, required 0 1", rsp_valid3, req_ready3);
    end
  endtask

  task automatic test_cond_sweep();
    exp_t e;
    int k;
    for (int f = 0; f < 16; f++) begin
      alu_flags = 4'(f); alu_result = 32'hF1A6_0000;
      send(4'b1000, 1'b0, 4'b1110, 32'h0, 32'h0);
      wait_rsp(k);
      n_checks++;
      if (flags_q !== 4'(f)) begin
        n_errors++;
        $display("FAIL sweep_setflags: flags=%h, required %h", flags_q, 4'(f));
      end
      release_rsp();
      for (int c = 0; c < 16; c++) begin
        alu_flags = ~4'(f);
        alu_result = 32'hC0DE_0000 | 32'(f * 16 + c);
        e.exec   = ref_pass(4'(c), 4'(f));
        e.result = e.exec ? alu_result : 32'h0;
        e.flags  = 4'(f);
        e.lat    = e.exec ? 1 : 0;
        sb.push_back(e);
        send(4'b0000, 1'b0, 4'(c), $urandom, $urandom);
        wait_rsp(k);
        e = sb.pop_front();
        n_checks++;
        if ({k, rsp_executed, rsp_result, flags_q} !== {e.lat, e.exec, e.result, e.flags}) begin
          n_errors++;
          $display("FAIL sweep cond=%h flags=%h: lat=%0d exe=%b res=%h fq=%h, required %0d %b %h %h",
                   4'(c), 4'(f), k, rsp_executed, rsp_result, flags_q, e.lat, e.exec, e.result, e.flags);
        end
        $display("txn cond=%h flags=%h exe=%b res=%h", 4'(c), 4'(f), rsp_executed, rsp_result);
        release_rsp();
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    int n, seen;
    n = 0; seen = 0;
    alu_flags = 4'b1010; alu_result = 32'hBAD0_0000;
    @(negedge clk);
    req_opcode = 4'b0000; req_s_bit = 1'b1; req_cond = 4'b1110;
    req_in1 = 32'h9; req_in2 = 32'hA; req_valid3 = 1'b1;
    while (!req_ready3 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid3 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid3, req_ready3, flags3, flags_q} !== {1'b0, 1'b1, 4'h0, 4'h0}) begin
      n_errors++;
      $display("FAIL rst_mid: vld=%b rdy=%b flags3=%h flags=%h, required 0 1 0 0",
               rsp_valid3, req_ready3, flags3, flags_q);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid3) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_errors++;
      $display("FAIL rst_stale_rsp: rsp_valid seen %0d cycles, required 0", seen);
    end
    $display("txn reset-mid-exec flags3=%h", flags3);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0; rsp_ready = 1'b0; rsp_ready3 = 1'b0;
    req_opcode = 4'h0; req_s_bit = 1'b0; req_cond = 4'h0; req_in1 = 32'h0; req_in2 = 32'h0;
    alu_result = 32'h0; alu_flags = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_add_wrap();
    test_skip();
    test_cmp_nop();
    test_latency3_hold();
    test_cond_sweep();
    test_reset_mid_exec();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
